prover_compute_h_seq: RTL and testbench
=======================================

PROVER_COMPUTE_H_SEQ -- requirements
Module: prover_compute_h_seq

Interface
REQ-001 Parameter: DEPTH, default 4, entries in the input FIFO (power of two, at least 2).
REQ-002 Parameter: data width is `F_NBITS from field_arith_defs.v, not a module parameter.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  producer offers in_data/in_last this cycle.
REQ-006 in_data  input  `F_NBITS  field element to be summed.
REQ-007 in_last  input  1  element closes the current group.
REQ-008 in_ready  output  1  FIFO not full; push occurs when in_valid && in_ready.
REQ-009 acc_en  output  1  one-cycle issue strobe to the accumulator.
REQ-010 acc_in  output  `F_NBITS  element issued to the accumulator.
REQ-011 acc_tag  output  1  0 = first element of group (restart), 1 = accumulate onto running sum.
REQ-012 acc_ready_pulse  input  1  accumulator finished the outstanding operation.
REQ-013 acc_out  input  `F_NBITS  accumulator running sum, valid when acc_ready_pulse is high.
REQ-014 out_valid  output  1  one-cycle pulse, group sum available.
REQ-015 out_data  output  `F_NBITS  completed group sum, held until next out_valid.
REQ-016 busy  output  1  FIFO non-empty or operation outstanding.
REQ-017 err  output  1  sticky, acc_ready_pulse arrived while no operation outstanding.

Function
REQ-018 FSM states: IDLE (nothing outstanding) and WAIT (one accumulator op outstanding).
REQ-019 IDLE and FIFO non-empty: pop head, drive acc_en=1 with acc_in/acc_tag for exactly one cycle, enter WAIT.
REQ-020 acc_tag = 0 when the popped element is the first since reset or since the previous in_last element; otherwise 1.
REQ-021 Never more than one outstanding op; acc_en stays 0 throughout WAIT.
REQ-022 WAIT and acc_ready_pulse: return to IDLE; if the issued element had in_last=1, register acc_out into out_data and pulse out_valid the next cycle.
REQ-023 Earliest issue after the ready pulse is the next cycle, which may coincide with out_valid.
REQ-024 Push latency: element pushed in cycle t is issued no earlier than cycle t+1.
REQ-025 in_ready = !full from registered state; no push when full.
REQ-026 Push into an empty FIFO while IDLE is still registered first, with no combinational bypass.
REQ-027 Simultaneous push and pop when not full are both performed; the occupancy count is unchanged.
REQ-028 Pointers wrap modulo DEPTH; ordering is strictly FIFO.
REQ-029 acc_ready_pulse in IDLE: ignored except err <= 1.
REQ-030 A single-element group (first element has in_last=1) issues with acc_tag=0 and produces out_data = that element.

Reset
REQ-031 On rst: FIFO emptied, state IDLE, first-flag = 1, err = 0.
REQ-032 On rst: in_ready=0 during the reset cycle and 1 after; acc_en=0, out_valid=0, out_data=0, busy=0.
REQ-033 Reset mid-operation abandons the group; a later acc_ready_pulse for the abandoned op sets err and produces no out_valid.

Configuration
REQ-034 Macro PROVER_COMPUTE_H_SEQ_COUNT_EN, when defined, adds output out_count [15:0]: the number of elements in the completed group, valid with out_valid, saturating at 16'hFFFF, reset 0.
REQ-035 Without PROVER_COMPUTE_H_SEQ_COUNT_EN, no out_count port and no counter logic; all other behaviour is identical.

Verification
REQ-036 Push 3, 5, 7 (last on 7); accumulator model with 3-cycle latency -> acc_tag sequence 0,1,1; one out_valid with out_data=15; out_count=3 if enabled.
REQ-037 Push groups {9 last} then {2, 4 last} back-to-back -> out_data 9, then 6; the first issue of the second group has acc_tag=0.
REQ-038 Hold the accumulator (no ready pulse) and push DEPTH+2 elements -> in_ready=0 after DEPTH accepted; no loss or reorder once released.
REQ-039 acc_ready_pulse while IDLE after reset -> err=1 and remains 1; no out_valid.
REQ-040 Assert rst during WAIT of a 4-element group, then send {1, 1 last} -> stale pulse sets err; new sum = 2 with first acc_tag=0.
REQ-041 Sums near the modulus: push p-1 and 2 -> out_data equals the accumulator model output of 1; the block passes the sum through unchanged.

Source files
------------

// File: rtl/prover_compute_h_seq.sv
// prover_compute_h_seq
// Streams field elements from a small FIFO into an external multi-cycle
// accumulator, one operation at a time, and reports the running sum when a
// group (closed by in_last) completes.
// Optional feature macro: PROVER_COMPUTE_H_SEQ_COUNT_EN adds out_count, the
// element count of each completed group.
//
// Handshake: an element is pushed on a rising edge where in_valid && in_ready;
// in_ready depends only on registered occupancy (and rst), never on in_valid.
// acc_en is a single-cycle issue strobe; the accumulator answers with exactly
// one acc_ready_pulse per issue, and no new issue is made until it does.

`ifndef F_NBITS
`define F_NBITS 61
`endif

module prover_compute_h_seq #(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [`F_NBITS-1:0] in_data,
  input  logic                in_last,
  output logic                in_ready,
  output logic                acc_en,
  output logic [`F_NBITS-1:0] acc_in,
  output logic                acc_tag,
  input  logic                acc_ready_pulse,
  input  logic [`F_NBITS-1:0] acc_out,
  output logic                out_valid,
  output logic [`F_NBITS-1:0] out_data,
  output logic                busy,
  output logic                err
`ifdef PROVER_COMPUTE_H_SEQ_COUNT_EN
  ,
  output logic [15:0]         out_count
`endif
);

  localparam int W  = `F_NBITS;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {
    S_IDLE = 1'b0,   // nothing outstanding at the accumulator
    S_WAIT = 1'b1    // one operation outstanding
  } state_t;

  state_t state, state_nx;

  // FIFO storage: each entry is {last, data}
  logic [W:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty;
  logic          push, pop, done;
  logic [W:0]    head;

  // Running-group bookkeeping
  logic          first_flag;   // next issued element starts a new group
  logic          issued_last;  // element currently outstanding closes a group

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign in_ready = !rst && !full;
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];

  assign acc_en   = pop && !rst;
  assign acc_in   = head[W-1:0];
  assign acc_tag  = !first_flag;
  assign busy     = !empty || (state == S_WAIT);

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage write; contents need no reset since occupancy gates reads
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_last, in_data};
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // FSM next state: issue from IDLE when data is queued, retire on the pulse
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (acc_ready_pulse) begin
          done     = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Group tracking, result capture and sticky protocol error
  always_ff @(posedge clk) begin
    if (rst) begin
      first_flag  <= 1'b1;
      issued_last <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      err         <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (pop) begin
        first_flag  <= head[W];
        issued_last <= head[W];
      end
      if (done && issued_last) begin
        out_valid <= 1'b1;
        out_data  <= acc_out;
      end
      // A pulse with nothing outstanding (including one left over from an
      // operation abandoned by reset) is flagged and otherwise ignored.
      if ((state == S_IDLE) && acc_ready_pulse) err <= 1'b1;
    end
  end

`ifdef PROVER_COMPUTE_H_SEQ_COUNT_EN
  logic [15:0] grp_cnt;

  // Per-group element counter, saturating, latched on group completion
  always_ff @(posedge clk) begin
    if (rst) begin
      grp_cnt   <= '0;
      out_count <= '0;
    end else begin
      if (pop) begin
        if (first_flag)                grp_cnt <= 16'd1;
        else if (grp_cnt != 16'hFFFF)  grp_cnt <= grp_cnt + 16'd1;
      end
      if (done && issued_last) out_count <= grp_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_prover_compute_h_seq.sv
// Testbench for prover_compute_h_seq: table-driven directed groups, corner
// sequences around back-pressure and reset, then randomized traffic checked
// against a group-sum reference model and a behavioural accumulator.

`ifndef F_NBITS
`define F_NBITS 61
`endif

module tb_prover_compute_h_seq;

  localparam int DEPTH = 4;
  localparam int W     = `F_NBITS;
  localparam logic [63:0] P = (64'd1 << W) - 64'd1;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic         acc_en;
  logic [W-1:0] acc_in;
  logic         acc_tag;
  logic         acc_ready_pulse = 1'b0;
  logic [W-1:0] acc_out = '0;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         busy;
  logic         err;
`ifdef PROVER_COMPUTE_H_SEQ_COUNT_EN
  logic [15:0]  out_count;
`endif

  always #5 clk = ~clk;

  prover_compute_h_seq #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .acc_en(acc_en), .acc_in(acc_in), .acc_tag(acc_tag),
    .acc_ready_pulse(acc_ready_pulse), .acc_out(acc_out),
    .out_valid(out_valid), .out_data(out_data), .busy(busy), .err(err)
`ifdef PROVER_COMPUTE_H_SEQ_COUNT_EN
    , .out_count(out_count)
`endif
  );

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] sat16(input int n);
    return (n >= 65535) ? 16'hFFFF : 16'(n);
  endfunction

  // Reference model state (group sums computed from the pushed stream)
  logic [W-1:0] exp_data_q[$];
  bit           exp_tag_q[$];
  logic [W-1:0] exp_q[$];
  logic [15:0]  exp_cnt_q[$];
  bit           ref_first = 1'b1;
  logic [63:0]  ref_sum = '0;
  int           ref_cnt = 0;

  // Observation logs (append-only; readers use a base index)
  bit           obs_tag_q[$];
  logic [W-1:0] obs_sum_q[$];
  logic [15:0]  obs_cnt_q[$];
  int           n_out = 0;

  // Behavioural accumulator controls
  logic [63:0]  acc_sum = '0;
  bit           acc_busy = 1'b0;
  int           acc_cnt = 0;
  bit           acc_hold = 1'b0;
  int           lat_min = 3;
  int           lat_max = 3;
  int           force_req = 0;
  int           force_ack = 0;

  // ---------------- accumulator model + scoreboard (negedge) ----------------
  initial begin
    forever begin
      @(negedge clk);
      acc_ready_pulse = 1'b0;
      if (rst) begin
        exp_data_q.delete();
        exp_tag_q.delete();
        exp_q.delete();
        exp_cnt_q.delete();
        ref_first = 1'b1;
        ref_cnt   = 0;
      end else begin
        // issue checked before this cycle's push so a same-cycle bypass shows up
        if (acc_en) begin
          obs_tag_q.push_back(acc_tag);
          if (acc_busy) chk("acc_en_while_outstanding", acc_en, 0);
          if (exp_data_q.size() == 0) chk("spurious_acc_en", acc_en, 0);
          else begin
            chk("acc_in", acc_in, exp_data_q.pop_front());
            chk("acc_tag", acc_tag, exp_tag_q.pop_front());
          end
          acc_sum  = acc_tag ? (acc_sum + 64'(acc_in)) % P : 64'(acc_in);
          acc_busy = 1'b1;
          acc_cnt  = $urandom_range(lat_max, lat_min);
        end else if (acc_busy && !acc_hold && force_req == force_ack) begin
          acc_cnt--;
          if (acc_cnt <= 0) begin
            acc_ready_pulse = 1'b1;
            acc_out         = acc_sum[W-1:0];
            acc_busy        = 1'b0;
          end
        end
        if (in_valid && in_ready) begin
          ref_sum = ref_first ? 64'(in_data) : (ref_sum + 64'(in_data)) % P;
          ref_cnt = ref_first ? 1 : ref_cnt + 1;
          exp_data_q.push_back(in_data);
          exp_tag_q.push_back(!ref_first);
          if (in_last) begin
            exp_q.push_back(ref_sum[W-1:0]);
            exp_cnt_q.push_back(sat16(ref_cnt));
          end
          ref_first = in_last;
        end
        if (out_valid) begin
          n_out++;
          obs_sum_q.push_back(out_data);
`ifdef PROVER_COMPUTE_H_SEQ_COUNT_EN
          obs_cnt_q.push_back(out_count);
`endif
          if (exp_q.size() == 0) chk("spurious_out_valid", out_valid, 0);
          else begin
            chk("out_data", out_data, exp_q.pop_front());
`ifdef PROVER_COMPUTE_H_SEQ_COUNT_EN
            chk("out_count", out_count, exp_cnt_q.pop_front());
`else
            void'(exp_cnt_q.pop_front());
`endif
          end
        end
      end
      // a manual pulse (stale completion or pulse while idle)
      if (force_req != force_ack) begin
        acc_ready_pulse = 1'b1;
        acc_out         = acc_sum[W-1:0];
        acc_busy        = 1'b0;
        force_ack       = force_req;
      end
    end
  end

  // ---------------- driver tasks (entered/left at posedge+1) ----------------
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("in_ready_during_reset", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_acc_en", acc_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
`ifdef PROVER_COMPUTE_H_SEQ_COUNT_EN
    chk("rst_out_count", out_count, 0);
`endif
    @(posedge clk); #1;
  endtask

  task automatic push_elem(input logic [W-1:0] d, input bit last, input int max_wait, output bit ok);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    ok = 1'b0;
    for (int i = 0; i < max_wait; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    bit idle = 1'b0;
    for (int i = 0; i < max_cycles && !idle; i++) begin
      @(negedge clk);
      idle = !busy && !acc_busy;
    end
    if (!idle) chk("idle_timeout", busy, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pulse_now();
    force_req++;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [W-1:0] data;
    bit           last;
    bit           exp_tag;
    logic [W-1:0] exp_sum;
    logic [15:0]  exp_cnt;
  } vec_t;

  vec_t tbl[8];

  initial begin
    bit ok;
    int base_t, base_s, base_c, k, nacc, outs0;
    logic [W-1:0] pm1;
    logic [63:0]  r;

    pm1 = P[W-1:0] - 1'b1;
    tbl[0] = '{3,   0, 0, 0, 0};
    tbl[1] = '{5,   0, 1, 0, 0};
    tbl[2] = '{7,   1, 1, 15, 3};
    tbl[3] = '{9,   1, 0, 9, 1};
    tbl[4] = '{2,   0, 0, 0, 0};
    tbl[5] = '{4,   1, 1, 6, 2};
    tbl[6] = '{pm1, 0, 0, 0, 0};
    tbl[7] = '{2,   1, 1, 1, 2};

    @(posedge clk); #1;
    do_reset();

    // groups {3,5,7}, {9}, {2,4}, {p-1,2} with 3-cycle accumulator
    lat_min = 3; lat_max = 3;
    base_t = obs_tag_q.size();
    base_s = obs_sum_q.size();
    base_c = obs_cnt_q.size();
    for (int i = 0; i < 8; i++) begin
      push_elem(tbl[i].data, tbl[i].last, 50, ok);
      chk($sformatf("tbl_push[%0d]", i), ok, 1);
    end
    wait_idle(200);
    chk("tbl_issue_count", obs_tag_q.size() - base_t, 8);
    chk("tbl_out_count", obs_sum_q.size() - base_s, 4);
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (base_t + i < obs_tag_q.size())
        chk($sformatf("tbl_tag[%0d]", i), obs_tag_q[base_t + i], tbl[i].exp_tag);
      if (tbl[i].last) begin
        if (base_s + k < obs_sum_q.size())
          chk($sformatf("tbl_sum[%0d]", i), obs_sum_q[base_s + k], tbl[i].exp_sum);
`ifdef PROVER_COMPUTE_H_SEQ_COUNT_EN
        if (base_c + k < obs_cnt_q.size())
          chk($sformatf("tbl_cnt[%0d]", i), obs_cnt_q[base_c + k], tbl[i].exp_cnt);
`endif
        k++;
      end
    end
    chk("out_data_held", out_data, 1);

    // back-pressure: hold the accumulator, fill the FIFO, then release
    lat_min = 1; lat_max = 1;
    acc_hold = 1'b1;
    base_s = obs_sum_q.size();
    push_elem(100, 0, 20, ok);
    chk("hold_first_push", ok, 1);
    nacc = 0;
    for (int i = 0; i < DEPTH; i++) begin
      push_elem(W'(101 + i), 0, 5, ok);
      if (ok) nacc++;
    end
    chk("hold_accepted", nacc, DEPTH);
    @(negedge clk);
    chk("hold_in_ready_full", in_ready, 0);
    chk("hold_busy", busy, 1);
    @(posedge clk); #1;
    push_elem(200, 0, 4, ok);
    chk("hold_push_refused", ok, 0);
    acc_hold = 1'b0;
    push_elem(200, 0, 50, ok);
    chk("release_push_a", ok, 1);
    push_elem(201, 1, 50, ok);
    chk("release_push_b", ok, 1);
    wait_idle(200);
    if (base_s < obs_sum_q.size()) chk("hold_sum", obs_sum_q[base_s], 911);
    else chk("hold_sum_missing", obs_sum_q.size(), base_s + 1);

    // pulse while idle after reset: sticky err, no output
    do_reset();
    outs0 = n_out;
    pulse_now();
    @(negedge clk);
    chk("idle_pulse_err", err, 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("idle_pulse_err_sticky", err, 1);
    chk("idle_pulse_no_out", n_out, outs0);
    @(posedge clk); #1;

    // reset during WAIT of a 4-element group, stale pulse, then {1, 1 last}
    do_reset();
    lat_min = 3; lat_max = 3;
    acc_hold = 1'b1;
    push_elem(10, 0, 20, ok);
    push_elem(20, 0, 20, ok);
    push_elem(30, 0, 20, ok);
    push_elem(40, 1, 20, ok);
    @(negedge clk);
    chk("mid_group_busy", busy, 1);
    @(posedge clk); #1;
    outs0 = n_out;
    do_reset();
    pulse_now();
    @(negedge clk);
    chk("stale_pulse_err", err, 1);
    chk("stale_pulse_no_out", n_out, outs0);
    @(posedge clk); #1;
    acc_hold = 1'b0;
    base_t = obs_tag_q.size();
    base_s = obs_sum_q.size();
    push_elem(1, 0, 20, ok);
    push_elem(1, 1, 20, ok);
    wait_idle(200);
    if (base_t < obs_tag_q.size()) chk("after_reset_first_tag", obs_tag_q[base_t], 0);
    else chk("after_reset_issue_missing", obs_tag_q.size(), base_t + 1);
    if (base_s < obs_sum_q.size()) chk("after_reset_sum", obs_sum_q[base_s], 2);
    else chk("after_reset_sum_missing", obs_sum_q.size(), base_s + 1);

    // randomized traffic against the reference model
    do_reset();
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 80; i++) begin
      r = {$urandom(), $urandom()} % P;
      push_elem(r[W-1:0], (i == 79) || ($urandom_range(3, 0) == 0), 100, ok);
      if (!ok) chk("rand_push", ok, 1);
      repeat ($urandom_range(2, 0)) @(posedge clk);
      #1;
    end
    wait_idle(500);
    chk("rand_groups_drained", exp_q.size(), 0);
    chk("rand_elems_drained", exp_data_q.size(), 0);
    chk("rand_err_clear", err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
